// File: rtl/gnn_pkg.sv
// -----------------------------------------------------------------------------
// gnn_pkg
// Definitions shared by the gnn_layer_seq block and its bench:
//   - state_t : layer FSM states (IDLE, AGG, MAC, DONE)
//   - agg_w   : width of a neighbour-sum (input width + log2 of the node count)
//   - out_w   : width of a layer output (aggregate * weight, summed over F_IN)
//   - cnt_w   : counter width able to index 0..n-1 (at least 1 bit)
//   - *_idx   : LSB positions of elements inside the flattened buses
// -----------------------------------------------------------------------------
package gnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AGG  = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int agg_w(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

  function automatic int out_w(input int aw, input int w_w, input int f_in);
    return aw + w_w + $clog2(f_in);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Node i, feature k of the feature bus.
  function automatic int x_idx(input int i, input int k, input int f_in, input int in_w);
    return (i * f_in + k) * in_w;
  endfunction

  // Bit set when node j feeds node i.
  function automatic int adj_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  // Weight from input feature k to output feature o.
  function automatic int w_idx(input int k, input int o, input int f_out, input int w_w);
    return (k * f_out + o) * w_w;
  endfunction

  // Node i, output feature o of the result bus.
  function automatic int y_idx(input int i, input int o, input int f_out, input int o_w);
    return (i * f_out + o) * o_w;
  endfunction

endpackage

// File: rtl/gnn_layer_seq_if.sv
// -----------------------------------------------------------------------------
// gnn_layer_seq_if
// Bundle-in / result-out handshake of one graph-convolution layer.
//   in_valid/in_ready   : input bundle handshake
//   x_flat, adj, w_flat : node features, adjacency mask, weight matrix
//   out_valid/out_ready : result handshake
//   y_flat              : per-node output features
// slave  = the layer, master = the producer/consumer driving it.
// -----------------------------------------------------------------------------
interface gnn_layer_seq_if #(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_OUT   = 2,
  parameter int IN_W    = 5,
  parameter int W_W     = 5
);
  import gnn_pkg::*;

  localparam int OUT_W = out_w(agg_w(IN_W, N_NODES), W_W, F_IN);

  logic                             in_valid;
  logic                             in_ready;
  logic [N_NODES*F_IN*IN_W-1:0]     x_flat;
  logic [N_NODES*N_NODES-1:0]       adj;
  logic [F_IN*F_OUT*W_W-1:0]        w_flat;
  logic                             out_valid;
  logic                             out_ready;
  logic [N_NODES*F_OUT*OUT_W-1:0]   y_flat;

  modport slave (
    input  in_valid, x_flat, adj, w_flat, out_ready,
    output in_ready, out_valid, y_flat
  );

  modport master (
    output in_valid, x_flat, adj, w_flat, out_ready,
    input  in_ready, out_valid, y_flat
  );

endinterface

// File: rtl/gnn_mac_unit.sv
// -----------------------------------------------------------------------------
// gnn_mac_unit
// Registered signed multiply-accumulate.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the accumulator (wins over en)
//   en       : accumulate a*b this cycle
//   a, b     : signed operands
//   sum      : accumulator plus the current product (combinational), so the
//              caller can take the finished dot product in the same cycle
//              that it clears the accumulator.
// ACC_W must be at least A_W+B_W.
// -----------------------------------------------------------------------------
module gnn_mac_unit #(
  parameter int A_W   = 7,
  parameter int B_W   = 5,
  parameter int ACC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0]   acc;
  logic signed [A_W+B_W-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/gnn_layer_seq.sv
// -----------------------------------------------------------------------------
// gnn_layer_seq
// Time-multiplexed graph-convolution layer:
//   y[i][o] = act( sum_k ( sum_{j feeds i} x[j][k] ) * w[k][o] )
// A bundle is captured in IDLE, neighbour sums are built in AGG (one (i,j)
// pair per cycle, all features in parallel), the weight matrix is applied in
// MAC (one product per cycle on a shared multiplier), and the result is held
// in DONE until the consumer takes it.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gnn_layer_seq_if.slave (bundle in, result out)
//   busy     : FSM is not in IDLE
// -----------------------------------------------------------------------------
module gnn_layer_seq
  import gnn_pkg::*;
#(
  parameter int N_NODES   = 4,
  parameter int F_IN      = 4,
  parameter int F_OUT     = 2,
  parameter int IN_W      = 5,
  parameter int W_W       = 5,
  parameter int SELF_LOOP = 1,
  parameter int RELU_EN   = 1
) (
  input  logic            clk,
  input  logic            rst,
  gnn_layer_seq_if.slave  bus,
  output logic            busy
);

  localparam int AGG_W = agg_w(IN_W, N_NODES);
  localparam int OUT_W = out_w(AGG_W, W_W, F_IN);
  localparam int NW    = cnt_w(N_NODES);
  localparam int KW    = cnt_w(F_IN);
  localparam int OW    = cnt_w(F_OUT);

  state_t state, state_nxt;

  // AGG walks (ai, aj); MAC walks (mi, mo, mk). Innermost index runs fastest.
  logic [NW-1:0] ai, aj, mi;
  logic [OW-1:0] mo;
  logic [KW-1:0] mk;

  logic signed [IN_W-1:0]  x_r   [N_NODES][F_IN];
  logic                    adj_r [N_NODES][N_NODES];
  logic signed [W_W-1:0]   w_r   [F_IN][F_OUT];
  logic signed [AGG_W-1:0] agg_r [N_NODES][F_IN];
  logic signed [OUT_W-1:0] y_r   [N_NODES][F_OUT];

  logic                    capture, agg_last, agg_hit;
  logic                    k_last, o_last, i_last, mac_last;
  logic signed [OUT_W-1:0] mac_sum;
  logic [N_NODES*F_OUT*OUT_W-1:0] y_pack;

  assign capture  = (state == IDLE) && bus.in_valid;
  assign agg_last = (ai == NW'(N_NODES-1)) && (aj == NW'(N_NODES-1));
  assign agg_hit  = adj_r[ai][aj] || ((SELF_LOOP != 0) && (ai == aj));
  assign k_last   = (mk == KW'(F_IN-1));
  assign o_last   = (mo == OW'(F_OUT-1));
  assign i_last   = (mi == NW'(N_NODES-1));
  assign mac_last = i_last && o_last && k_last;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid)  state_nxt = AGG;
      AGG:  if (agg_last)      state_nxt = MAC;
      MAC:  if (mac_last)      state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Shared multiplier: aggregate of node mi, feature mk times weight mk->mo.
  // Cleared outside MAC and after each finished dot product.
  // ---------------------------------------------------------------------------
  gnn_mac_unit #(
    .A_W   (AGG_W),
    .B_W   (W_W),
    .ACC_W (OUT_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr ((state != MAC) || k_last),
    .en  (state == MAC),
    .a   (agg_r[mi][mk]),
    .b   (w_r[mk][mo]),
    .sum (mac_sum)
  );

  // ---------------------------------------------------------------------------
  // Capture, aggregation and result storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage arrays are reset explicitly because reset must abort to
  // an all-cleared state (y_flat reads 0 straight out of reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai <= '0; aj <= '0; mi <= '0; mo <= '0; mk <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        for (int k = 0; k < F_IN; k++) begin
          x_r[i][k]   <= '0;
          agg_r[i][k] <= '0;
        end
        for (int j = 0; j < N_NODES; j++) adj_r[i][j] <= 1'b0;
        for (int o = 0; o < F_OUT; o++)   y_r[i][o]   <= '0;
      end
      for (int k = 0; k < F_IN; k++)
        for (int o = 0; o < F_OUT; o++) w_r[k][o] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            ai <= '0; aj <= '0; mi <= '0; mo <= '0; mk <= '0;
            for (int i = 0; i < N_NODES; i++) begin
              for (int k = 0; k < F_IN; k++) begin
                x_r[i][k]   <= bus.x_flat[x_idx(i, k, F_IN, IN_W) +: IN_W];
                agg_r[i][k] <= '0;
              end
              for (int j = 0; j < N_NODES; j++)
                adj_r[i][j] <= bus.adj[adj_idx(i, j, N_NODES)];
            end
            for (int k = 0; k < F_IN; k++)
              for (int o = 0; o < F_OUT; o++)
                w_r[k][o] <= bus.w_flat[w_idx(k, o, F_OUT, W_W) +: W_W];
          end
        end

        AGG: begin
          if (agg_hit)
            for (int k = 0; k < F_IN; k++)
              agg_r[ai][k] <= agg_r[ai][k] + AGG_W'(x_r[aj][k]);
          if (aj == NW'(N_NODES-1)) begin
            aj <= '0;
            ai <= (ai == NW'(N_NODES-1)) ? '0 : ai + 1'b1;
          end else begin
            aj <= aj + 1'b1;
          end
        end

        MAC: begin
          if (k_last) begin
            y_r[mi][mo] <= ((RELU_EN != 0) && mac_sum[OUT_W-1]) ? '0 : mac_sum;
            mk <= '0;
            if (o_last) begin
              mo <= '0;
              mi <= i_last ? '0 : mi + 1'b1;
            end else begin
              mo <= mo + 1'b1;
            end
          end else begin
            mk <= mk + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  always_comb begin
    y_pack = '0;
    for (int i = 0; i < N_NODES; i++)
      for (int o = 0; o < F_OUT; o++)
        y_pack[y_idx(i, o, F_OUT, OUT_W) +: OUT_W] = y_r[i][o];
  end

  assign bus.y_flat = y_pack;

endmodule

// File: tb/tb_gnn_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_gnn_layer_seq
// Directed bench for gnn_layer_seq. dut0 uses the default configuration and
// is checked through a scoreboard queue filled at capture time; dut1 (no ReLU)
// and dut2 (3 nodes, 2 in / 3 out features, no self loop) cover the other
// configurations with fixed expected results.
// -----------------------------------------------------------------------------
module tb_gnn_layer_seq;
  import gnn_pkg::*;

  localparam int N   = 4, FI = 4, FO = 2, IW = 5, WW = 5;
  localparam int OW  = out_w(agg_w(IW, N), WW, FI);
  localparam int XB  = N*FI*IW, AB = N*N, WB = FI*FO*WW, YB = N*FO*OW;

  localparam int N2  = 3, FI2 = 2, FO2 = 3;
  localparam int OW2 = out_w(agg_w(IW, N2), WW, FI2);
  localparam int XB2 = N2*FI2*IW, AB2 = N2*N2, WB2 = FI2*FO2*WW, YB2 = N2*FO2*OW2;

  logic clk = 1'b0;
  logic rst;
  logic busy0, busy1, busy2;
  always #5 clk = ~clk;

  gnn_layer_seq_if #(.N_NODES(N),  .F_IN(FI),  .F_OUT(FO),  .IN_W(IW), .W_W(WW)) bus0 ();
  gnn_layer_seq_if #(.N_NODES(N),  .F_IN(FI),  .F_OUT(FO),  .IN_W(IW), .W_W(WW)) bus1 ();
  gnn_layer_seq_if #(.N_NODES(N2), .F_IN(FI2), .F_OUT(FO2), .IN_W(IW), .W_W(WW)) bus2 ();

  gnn_layer_seq #(.N_NODES(N), .F_IN(FI), .F_OUT(FO), .IN_W(IW), .W_W(WW),
                  .SELF_LOOP(1), .RELU_EN(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
  gnn_layer_seq #(.N_NODES(N), .F_IN(FI), .F_OUT(FO), .IN_W(IW), .W_W(WW),
                  .SELF_LOOP(1), .RELU_EN(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));
  gnn_layer_seq #(.N_NODES(N2), .F_IN(FI2), .F_OUT(FO2), .IN_W(IW), .W_W(WW),
                  .SELF_LOOP(0), .RELU_EN(0))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .busy(busy2));

  int tests = 0;
  int fails = 0;
  logic [YB-1:0] sb_q [$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: self loop on, ReLU on (dut0 configuration).
  function automatic logic [YB-1:0] model(input logic [XB-1:0] x, input logic [AB-1:0] a,
                                          input logic [WB-1:0] w);
    logic [YB-1:0] y;
    int s [FI];
    int r;
    y = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < FI; k++) begin
        s[k] = 0;
        for (int j = 0; j < N; j++)
          if (a[i*N+j] || i == j) s[k] += $signed(x[(j*FI+k)*IW +: IW]);
      end
      for (int o = 0; o < FO; o++) begin
        r = 0;
        for (int k = 0; k < FI; k++) r += s[k] * $signed(w[(k*FO+o)*WW +: WW]);
        if (r < 0) r = 0;
        y[(i*FO+o)*OW +: OW] = r[OW-1:0];
      end
    end
    return y;
  endfunction

  task automatic send0(input logic [XB-1:0] x, input logic [AB-1:0] a,
                       input logic [WB-1:0] w, input logic [YB-1:0] exp);
    @(negedge clk);
    check("in_ready_before_capture", bus0.in_ready, 1'b1);
    bus0.x_flat = x; bus0.adj = a; bus0.w_flat = w; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    sb_q.push_back(exp);
  endtask

  task automatic collect0(input string tag);
    int n = 0;
    while (bus0.out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_out_valid"}, bus0.out_valid, 1'b1);
    if (sb_q.size() > 0) check(tag, bus0.y_flat, sb_q.pop_front());
    @(negedge clk); bus0.out_ready = 1'b1;
    @(posedge clk); #1; bus0.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, bus0.out_valid, 1'b0);
    check({tag, "_in_ready_back"}, bus0.in_ready, 1'b1);
  endtask

  function automatic logic [XB-1:0] rand_x();
    logic [XB-1:0] v;
    for (int b = 0; b < XB; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [WB-1:0] rand_w();
    logic [WB-1:0] v;
    for (int b = 0; b < WB; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [AB-1:0] rand_a();
    logic [AB-1:0] v;
    for (int b = 0; b < AB; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XB-1:0] x;
    logic [AB-1:0] a;
    logic [WB-1:0] w;
    logic [YB-1:0] e, held;
    logic [XB2-1:0] x2;
    logic [AB2-1:0] a2;
    logic [WB2-1:0] w2;
    logic [YB2-1:0] e2;
    int n;

    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.x_flat = '0; bus0.adj = '0; bus0.w_flat = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.x_flat = '0; bus1.adj = '0; bus1.w_flat = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.x_flat = '0; bus2.adj = '0; bus2.w_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus0.in_ready,  1'b1);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_busy",      busy0,          1'b0);
    check("rst_y_flat",    bus0.y_flat,    '0);
    @(negedge clk); rst = 1'b0;

    // Latency and handshake: busy for 48 cycles, result on the 49th.
    x = rand_x(); a = rand_a(); w = rand_w();
    send0(x, a, w, model(x, a, w));
    for (int c = 0; c < 48; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      check($sformatf("busy_window_c%0d", c + 1), {busy0, bus0.in_ready, bus0.out_valid}, 3'b100);
    end
    @(posedge clk); #1;
    check("latency_out_valid_c49", bus0.out_valid, 1'b1);
    collect0("latency_result");

    // Self loop only, ReLU on: node0 x=[1,2,3,4], weights column0 +1, column1 -1.
    x = '0; x[0 +: IW] = 5'd1; x[IW +: IW] = 5'd2; x[2*IW +: IW] = 5'd3; x[3*IW +: IW] = 5'd4;
    w = '0;
    for (int k = 0; k < FI; k++) begin
      w[(k*FO+0)*WW +: WW] = 5'd1;
      w[(k*FO+1)*WW +: WW] = 5'b11111;
    end
    e = '0; e[0 +: OW] = 14'd10;
    send0(x, '0, w, e);
    collect0("self_loop_relu");

    // Same bundle on the ReLU-disabled instance: y[0][1] = -10.
    @(negedge clk);
    bus1.x_flat = x; bus1.adj = '0; bus1.w_flat = w; bus1.in_valid = 1'b1;
    @(posedge clk); #1; bus1.in_valid = 1'b0;
    n = 0;
    while (bus1.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check("self_loop_raw_out_valid", bus1.out_valid, 1'b1);
    e = '0; e[0 +: OW] = 14'd10; e[OW +: OW] = -14'sd10;
    check("self_loop_raw", bus1.y_flat, e);
    @(negedge clk); bus1.out_ready = 1'b1;
    @(posedge clk); #1; bus1.out_ready = 1'b0;
    check("self_loop_raw_release", bus1.in_ready, 1'b1);

    // Extreme values: every output is 4096.
    x = {(N*FI){5'b10000}};
    w = {(FI*FO){5'b10000}};
    e = {(N*FO){14'd4096}};
    send0(x, '1, w, e);
    collect0("extreme_values");

    // Backpressure with in_valid pulsing in DONE.
    x = rand_x(); a = rand_a(); w = rand_w();
    e = model(x, a, w);
    send0(x, a, w, e);
    n = 0;
    while (bus0.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus0.in_valid = (c % 2 == 0);
      bus0.x_flat = rand_x();
      @(posedge clk); #1;
      check($sformatf("bp_hold_c%0d", c), {bus0.out_valid, bus0.in_ready}, 2'b10);
      check($sformatf("bp_y_c%0d", c), bus0.y_flat, e);
    end
    @(negedge clk); bus0.in_valid = 1'b0;
    collect0("backpressure");
    check("bp_y_held_after_release", bus0.y_flat, e);
    @(posedge clk); #1;
    check("bp_no_capture", busy0, 1'b0);

    // Two more random bundles through the scoreboard.
    for (int t = 0; t < 2; t++) begin
      x = rand_x(); a = rand_a(); w = rand_w();
      send0(x, a, w, model(x, a, w));
      collect0($sformatf("random_%0d", t));
    end

    // Reset 20 cycles after capture (inside MAC): abort with nothing presented.
    x = rand_x(); a = rand_a(); w = rand_w();
    send0(x, a, w, model(x, a, w));
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", bus0.out_valid, 1'b0);
    check("abort_y_flat",    bus0.y_flat,    '0);
    check("abort_in_ready",  bus0.in_ready,  1'b1);
    check("abort_busy",      busy0,          1'b0);
    void'(sb_q.pop_back());
    @(negedge clk); rst = 1'b0;
    x = rand_x(); a = rand_a(); w = rand_w();
    send0(x, a, w, model(x, a, w));
    collect0("after_abort");

    // Asymmetric graph on the 3-node instance: only node1 feeds node0.
    x2 = '0;
    x2[0 +: IW] = 5'd5;         x2[IW +: IW] = 5'd5;
    x2[2*IW +: IW] = 5'd2;      x2[3*IW +: IW] = 5'b11101;
    x2[4*IW +: IW] = 5'd7;      x2[5*IW +: IW] = 5'b11001;
    a2 = '0; a2[0*N2+1] = 1'b1;
    w2 = '0;
    w2[0 +: WW] = 5'd1; w2[WW +: WW] = 5'd2; w2[2*WW +: WW] = 5'd3;
    w2[3*WW +: WW] = 5'd1; w2[4*WW +: WW] = 5'd1; w2[5*WW +: WW] = 5'd1;
    e2 = '0;
    e2[0 +: OW2] = -13'sd1; e2[OW2 +: OW2] = 13'd1; e2[2*OW2 +: OW2] = 13'd3;
    @(negedge clk);
    bus2.x_flat = x2; bus2.adj = a2; bus2.w_flat = w2; bus2.in_valid = 1'b1;
    @(posedge clk); #1; bus2.in_valid = 1'b0;
    n = 0;
    while (bus2.out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check("asym_out_valid", bus2.out_valid, 1'b1);
    check("asym_result", bus2.y_flat, e2);
    @(negedge clk); bus2.out_ready = 1'b1;
    @(posedge clk); #1; bus2.out_ready = 1'b0;
    check("asym_release", {busy2, bus2.in_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
